// File: rtl/cdb_arbiter.sv
// Common data bus: round-robin arbitration of N_SRC result ports onto N_BUS
// registered broadcast buses, with same-cycle grant, flush and source IDs.
module cdb_arbiter #(
    parameter  int DATA_W = 64,
    parameter  int N_SRC  = 4,
    parameter  int N_BUS  = 2,
    localparam int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_SRC-1:0]        src_req,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]        src_gnt,
    input  logic                    flush,
    output logic [N_BUS-1:0]        bus_valid,
    output logic [N_BUS*DATA_W-1:0] bus_data,
    output logic [N_BUS*SRC_W-1:0]  bus_src,
    output logic [SRC_W-1:0]        dbg_rr_ptr
);

    logic [SRC_W-1:0]  r_rr_ptr;
    logic [N_BUS-1:0]  r_bus_valid;
    logic [DATA_W-1:0] r_bus_data [N_BUS];
    logic [SRC_W-1:0]  r_bus_src  [N_BUS];

    logic [DATA_W-1:0] w_src_word [N_SRC];
    logic [N_BUS-1:0]  w_win_vld;
    logic [SRC_W-1:0]  w_win_idx  [N_BUS];
    logic [N_SRC-1:0]  w_win_mask;
    logic [SRC_W-1:0]  w_last;
    logic              w_any;
    logic [SRC_W-1:0]  w_ptr_nxt;

    genvar g;
    generate
        for (g = 0; g < N_SRC; g++) begin : g_unpack
            assign w_src_word[g] = src_data[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Scan from the round-robin pointer; the k-th requester found takes bus k.
    always_comb begin
        logic [SRC_W:0]   sum;
        logic [SRC_W-1:0] idx;
        int               cnt;
        w_win_vld  = '0;
        w_win_mask = '0;
        w_last     = '0;
        w_any      = 1'b0;
        sum        = '0;
        idx        = '0;
        cnt        = 0;
        for (int b = 0; b < N_BUS; b++) begin
            w_win_idx[b] = '0;
        end
        for (int k = 0; k < N_SRC; k++) begin
            sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (sum >= (SRC_W+1)'(N_SRC)) begin
                sum = sum - (SRC_W+1)'(N_SRC);
            end
            idx = sum[SRC_W-1:0];
            if (src_req[idx] && (cnt < N_BUS)) begin
                for (int b = 0; b < N_BUS; b++) begin
                    if (cnt == b) begin
                        w_win_vld[b] = 1'b1;
                        w_win_idx[b] = idx;
                    end
                end
                w_win_mask[idx] = 1'b1;
                w_last          = idx;
                w_any           = 1'b1;
                cnt             = cnt + 1;
            end
        end
    end

    assign w_ptr_nxt = (w_last == SRC_W'(N_SRC - 1)) ? '0 : w_last + SRC_W'(1);

    // Grants are suppressed during flush and while reset is asserted.
    assign src_gnt = (rst_n && !flush) ? w_win_mask : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_bus_valid <= '0;
            for (int b = 0; b < N_BUS; b++) begin
                r_bus_data[b] <= '0;
                r_bus_src[b]  <= '0;
            end
        end else if (flush) begin
            r_bus_valid <= '0;
        end else begin
            for (int b = 0; b < N_BUS; b++) begin
                r_bus_valid[b] <= w_win_vld[b];
                if (w_win_vld[b]) begin
                    r_bus_data[b] <= w_src_word[w_win_idx[b]];
                    r_bus_src[b]  <= w_win_idx[b];
                end
            end
            if (w_any) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

    assign bus_valid  = r_bus_valid;
    assign dbg_rr_ptr = r_rr_ptr;

    generate
        for (g = 0; g < N_BUS; g++) begin : g_pack
            assign bus_data[g*DATA_W +: DATA_W] = r_bus_data[g];
            assign bus_src[g*SRC_W +: SRC_W]    = r_bus_src[g];
        end
    endgenerate

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed table-driven bench for cdb_arbiter (N_SRC=4, N_BUS=2, DATA_W=64).
module tb_cdb_arbiter;

    localparam int DATA_W = 64;
    localparam int N_SRC  = 4;
    localparam int N_BUS  = 2;
    localparam int SRC_W  = 2;

    logic                    clk;
    logic                    rst_n;
    logic [N_SRC-1:0]        src_req;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC-1:0]        src_gnt;
    logic                    flush;
    logic [N_BUS-1:0]        bus_valid;
    logic [N_BUS*DATA_W-1:0] bus_data;
    logic [N_BUS*SRC_W-1:0]  bus_src;
    logic [SRC_W-1:0]        dbg_rr_ptr;

    cdb_arbiter #(.DATA_W(DATA_W), .N_SRC(N_SRC), .N_BUS(N_BUS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_req    (src_req),
        .src_data   (src_data),
        .src_gnt    (src_gnt),
        .flush      (flush),
        .bus_valid  (bus_valid),
        .bus_data   (bus_data),
        .bus_src    (bus_src),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] req;
        logic       flsh;
        logic [3:0] gnt;
        logic [1:0] vld;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [1:0] ptr;
    } vec_t;

    vec_t        vecs [15];
    logic [63:0] exp_q [$];
    int          checks;
    int          failures;
    logic [1:0]  prev_vld;

    function automatic logic [63:0] word_of(input int i);
        return 64'hABCD_0000_0000_0040 + 64'(i);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic flsh);
        src_req = req;
        flush   = flsh;
    endtask

    task automatic check_bus(input string tag, input logic [1:0] vld, input logic [1:0] s0,
                             input logic [1:0] s1, input logic [1:0] ptr);
        logic [63:0] e0;
        logic [63:0] e1;
        e0 = exp_q.pop_front();
        e1 = exp_q.pop_front();
        chk({tag, " bus_valid"}, 128'(bus_valid), 128'(vld));
        chk({tag, " bus_src0"},  128'(bus_src[1:0]), 128'(s0));
        chk({tag, " bus_src1"},  128'(bus_src[3:2]), 128'(s1));
        chk({tag, " bus_data0"}, 128'(bus_data[63:0]), 128'(e0));
        chk({tag, " bus_data1"}, 128'(bus_data[127:64]), 128'(e1));
        chk({tag, " rr_ptr"},    128'(dbg_rr_ptr), 128'(ptr));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        //                req      fl    gnt      vld    s0  s1  ptr
        vecs[0]  = '{4'b1111, 1'b0, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2};
        vecs[1]  = '{4'b1111, 1'b0, 4'b1100, 2'b11, 2'd2, 2'd3, 2'd0};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1100, 2'b11, 2'd2, 2'd3, 2'd0};
        vecs[4]  = '{4'b0100, 1'b0, 4'b0100, 2'b01, 2'd2, 2'd3, 2'd3};
        vecs[5]  = '{4'b1001, 1'b0, 4'b1001, 2'b11, 2'd3, 2'd0, 2'd1};
        vecs[6]  = '{4'b0011, 1'b1, 4'b0000, 2'b00, 2'd3, 2'd0, 2'd1};
        vecs[7]  = '{4'b0011, 1'b0, 4'b0011, 2'b11, 2'd1, 2'd0, 2'd1};
        vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 2'b00, 2'd1, 2'd0, 2'd1};
        vecs[9]  = '{4'b0111, 1'b0, 4'b0110, 2'b11, 2'd1, 2'd2, 2'd3};
        vecs[10] = '{4'b0111, 1'b0, 4'b0011, 2'b11, 2'd0, 2'd1, 2'd2};
        vecs[11] = '{4'b1110, 1'b0, 4'b1100, 2'b11, 2'd2, 2'd3, 2'd0};
        vecs[12] = '{4'b1000, 1'b0, 4'b1000, 2'b01, 2'd3, 2'd3, 2'd0};
        vecs[13] = '{4'b0010, 1'b0, 4'b0010, 2'b01, 2'd1, 2'd3, 2'd2};
        vecs[14] = '{4'b1111, 1'b0, 4'b1100, 2'b11, 2'd2, 2'd3, 2'd0};

        for (int i = 0; i < N_SRC; i++) begin
            src_data[i*DATA_W +: DATA_W] = word_of(i);
        end

        // reset held with all sources requesting
        rst_n = 1'b0;
        drive(4'b1111, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset src_gnt",   128'(src_gnt), 128'(0));
        chk("reset bus_valid", 128'(bus_valid), 128'(0));
        chk("reset bus_data",  128'(bus_data), 128'(0));
        chk("reset bus_src",   128'(bus_src), 128'(0));
        chk("reset rr_ptr",    128'(dbg_rr_ptr), 128'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;

        prev_vld = 2'b00;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].flsh);
            #1;
            chk($sformatf("v%0d src_gnt", i), 128'(src_gnt), 128'(vecs[i].gnt));
            chk($sformatf("v%0d pre_edge_valid", i), 128'(bus_valid), 128'(prev_vld));
            exp_q.push_back(word_of(int'(vecs[i].s0)));
            exp_q.push_back(word_of(int'(vecs[i].s1)));
            @(posedge clk);
            #1;
            check_bus($sformatf("v%0d", i), vecs[i].vld, vecs[i].s0, vecs[i].s1, vecs[i].ptr);
            prev_vld = vecs[i].vld;
        end

        // async reset between edges while both buses are valid
        #1 rst_n = 1'b0;
        #1;
        chk("midrst bus_valid", 128'(bus_valid), 128'(0));
        chk("midrst src_gnt",   128'(src_gnt), 128'(0));
        chk("midrst rr_ptr",    128'(dbg_rr_ptr), 128'(0));
        chk("midrst bus_data",  128'(bus_data), 128'(0));
        @(posedge clk);
        #1;
        chk("midrst hold bus_valid", 128'(bus_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst src_gnt", 128'(src_gnt), 128'(4'b0011));
        exp_q.push_back(word_of(0));
        exp_q.push_back(word_of(1));
        @(posedge clk);
        #1;
        check_bus("postrst", 2'b11, 2'd0, 2'd1, 2'd2);

        // a lone flush with no requests keeps pointer and kills the broadcast
        @(negedge clk);
        drive(4'b0000, 1'b1);
        #1;
        chk("idle_flush src_gnt", 128'(src_gnt), 128'(0));
        exp_q.push_back(word_of(0));
        exp_q.push_back(word_of(1));
        @(posedge clk);
        #1;
        check_bus("idle_flush", 2'b00, 2'd0, 2'd1, 2'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
